// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencing controller:
// FSM state encoding, PC-mux select codes and the PC width.
package fetch_pkg;

  // Encoding is visible on the state_o debug port, so the values are fixed.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  // {PC_sel, jump_sel} codes for the PC mux; 2'b11 is never driven.
  localparam logic [1:0] SEL_PC1 = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b10;
  localparam logic [1:0] SEL_J   = 2'b01;

  localparam int PC_W = 10;

endpackage

// File: rtl/bubble_counter.sv
// Loadable down-counter used for both the boot and the post-redirect bubble
// countdowns. Load has priority over decrement; decrement stops at zero.
module bubble_counter #(
  parameter int CNT_W   = 4,
  parameter int RST_VAL = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  // Count register: reset to the boot length, reload on redirect/resume.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      count <= CNT_W'(RST_VAL);
    else if (load)
      count <= load_val;
    else if (dec && !zero)
      count <= count - CNT_W'(1);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller. Arbitrates redirect, halt and
// stall requests into one fetch action per cycle and inserts bubbles after
// boot, redirect and resume to cover the instruction-memory read latency.
// Optional build macro FETCH_CTRL_PERF_EN adds stall/bubble perf counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int BOOT_CYCLES  = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        branch_taken,
  input  logic        jump_req,
  input  logic        stall_req,
  input  logic        halt_req,
  input  logic        resume,
  output logic        PC_write,
  output logic        PC_sel,
  output logic        jump_sel,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        fetch_valid,
  output logic [1:0]  state_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] bubble_cnt
`endif
);

  localparam logic [CNT_W-1:0] FLUSH_VAL = CNT_W'(FLUSH_CYCLES);
  // With no extra bubbles a redirect returns straight to RUN.
  localparam state_t AFTER_REDIRECT = (FLUSH_CYCLES > 0) ? FLUSH : RUN;

  state_t           state, next_state;
  logic [1:0]       pc_mux;
  logic             cnt_load, cnt_dec, cnt_zero, cnt_expire;
  logic [CNT_W-1:0] cnt;
  logic             stall_win;

  bubble_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL (BOOT_CYCLES)
  ) u_bubble_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (FLUSH_VAL),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // The countdown ends on the edge where the counter steps from 1 to 0.
  assign cnt_expire = cnt_zero || (cnt == CNT_W'(1));

  assign {PC_sel, jump_sel} = pc_mux;
  assign state_o            = state;

  // State register; asynchronous reset forces BOOT, whose outputs are the reset values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= BOOT;
    else          state <= next_state;
  end

  // Next-state and output decode; defaults describe a flush bubble that holds PC.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    next_state  = state;
    PC_write    = 1'b0;
    pc_mux      = SEL_PC1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b1;
    fetch_valid = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    stall_win   = 1'b0;
    unique case (state)
      BOOT: begin
        cnt_dec = 1'b1;
        if (cnt_expire) next_state = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          PC_write   = 1'b1;
          pc_mux     = SEL_BR;
          cnt_load   = 1'b1;
          next_state = AFTER_REDIRECT;
        end else if (jump_req) begin
          PC_write   = 1'b1;
          pc_mux     = SEL_J;
          cnt_load   = 1'b1;
          next_state = AFTER_REDIRECT;
        end else if (halt_req) begin
          next_state = HALT;
        end else if (stall_req) begin
          IF_ID_write = 1'b0;
          IF_ID_flush = 1'b0;
          stall_win   = 1'b1;
        end else begin
          PC_write    = 1'b1;
          IF_ID_flush = 1'b0;
          fetch_valid = 1'b1;
        end
      end
      FLUSH: begin
        PC_write = 1'b1;
        // Only a branch is honoured here; other requests come from flushed slots.
        if (branch_taken) begin
          pc_mux     = SEL_BR;
          cnt_load   = 1'b1;
          next_state = AFTER_REDIRECT;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_expire) next_state = RUN;
        end
      end
      HALT: begin
        IF_ID_write = 1'b0;
        IF_ID_flush = 1'b0;
        if (resume) begin
          cnt_load   = 1'b1;
          next_state = AFTER_REDIRECT;
        end
      end
      default: next_state = BOOT;
    endcase
  end

`ifdef FETCH_CTRL_PERF_EN
  // Saturating perf counters: stalls that won arbitration and post-boot bubbles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_win && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (IF_ID_flush && state != BOOT && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule
